// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA request/priority front end.
//   arb_state_e    - arbiter FSM states
//   DMA_NUM_CH     - default channel count
//   DACK_INACTIVE  - idle level of a DACK line for a given polarity setting
package dma_pkg;

  localparam int DMA_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    GRANTED = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Idle level of one DACK line: low when DACK is active-high, high otherwise.
  function automatic logic DACK_INACTIVE(input logic dack_active_high);
    return ~dack_active_high;
  endfunction

endpackage

// File: rtl/dma_priority_picker.sv
// dma_priority_picker: combinational winner selection.
//   eff    in  NUM_CH  qualified requests
//   ptr    in  W       highest-priority channel this cycle
//   winner out W       first set bit of eff scanning upward from ptr (wraps)
//   any    out 1       at least one qualified request
module dma_priority_picker #(
  parameter  int NUM_CH = 4,
  localparam int W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eff,
  input  logic [W-1:0]      ptr,
  output logic [W-1:0]      winner,
  output logic              any
);

  logic [W-1:0] idx;

  // Scan from the lowest-priority offset down to ptr itself so the
  // last hit (closest to ptr) is the one that sticks.
  always_comb begin
    int s;
    winner = '0;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= NUM_CH) s = s - NUM_CH;
      idx = W'(s);
      if (eff[idx]) winner = idx;
    end
  end

  assign any = |eff;

endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 8237A-style request qualification, priority pick and
// HRQ/HLDA handshake feeding the DMA timing FSM.
//   CLK, RESET          clock, synchronous active-high reset
//   dreq, hlda          raw channel requests, CPU hold acknowledge
//   maskReg, reqReg     channel mask, software requests (never masked)
//   cmdDisable          controller disable
//   cmdRotate           rotating priority select
//   dreqActiveLow       DREQ polarity
//   dackActiveHigh      DACK polarity
//   serviceDone         transfer-complete pulse from the timing FSM
//   hrq, dack           hold request, per-channel acknowledge
//   validDREQ           qualified request pending (registered)
//   validDACK           bus owned and grant active
//   activeCh            granted or pending channel
// Build option: DMA_ROTATE_PRIORITY_EN enables the rotating priority pointer;
// without it the pointer is tied to 0 and cmdRotate is ignored.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter  int NUM_CH = DMA_NUM_CH,
  localparam int W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              hlda,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] reqReg,
  input  logic              cmdDisable,
  input  logic              cmdRotate,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              serviceDone,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic              validDREQ,
  output logic              validDACK,
  output logic [W-1:0]      activeCh
);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] dreq_q, dreq_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [W-1:0]      active_ch_q, active_ch_d;
  logic              hrq_q, hrq_d;
  logic              valid_dreq_q, valid_dreq_d;
  logic              valid_dack_q, valid_dack_d;
  logic [W-1:0]      ptr;
  logic              ptr_upd;

  logic [NUM_CH-1:0] dreq_n, eff;
  logic [W-1:0]      winner;
  logic              any;

  always_comb begin
    dreq_d       = dreq;
    dreq_n       = dreqActiveLow ? ~dreq_q : dreq_q;
    eff          = cmdDisable ? '0 : ((dreq_n & ~maskReg) | reqReg);
    valid_dreq_d = |eff;
  end

  dma_priority_picker #(.NUM_CH(NUM_CH)) u_picker (
    .eff    (eff),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d      = state_q;
    hrq_d        = hrq_q;
    grant_d      = grant_q;
    valid_dack_d = valid_dack_q;
    active_ch_d  = active_ch_q;
    ptr_upd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          hrq_d       = 1'b1;
          active_ch_d = winner;
          state_d     = REQUEST;
        end
      end
      REQUEST: begin
        // Grant goes to the channel already latched; it stops tracking
        // the picker once the bus is ours.
        if (hlda) begin
          grant_d              = '0;
          grant_d[active_ch_q] = 1'b1;
          valid_dack_d         = 1'b1;
          state_d              = GRANTED;
        end else if (!any) begin
          hrq_d   = 1'b0;
          state_d = IDLE;
        end else begin
          active_ch_d = winner;
        end
      end
      GRANTED: begin
        // Bus loss ends service without rotating; done wins if both occur.
        if (serviceDone || !hlda) begin
          hrq_d        = 1'b0;
          grant_d      = '0;
          valid_dack_d = 1'b0;
          ptr_upd      = serviceDone;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        if (!hlda) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Serviced channel drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_upd && cmdRotate)
      ptr_d = (active_ch_q == W'(NUM_CH - 1)) ? '0 : active_ch_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  logic rot_unused;
  assign rot_unused = cmdRotate ^ ptr_upd;
  assign ptr        = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      dreq_q       <= '0;
      grant_q      <= '0;
      active_ch_q  <= '0;
      hrq_q        <= 1'b0;
      valid_dreq_q <= 1'b0;
      valid_dack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dreq_q       <= dreq_d;
      grant_q      <= grant_d;
      active_ch_q  <= active_ch_d;
      hrq_q        <= hrq_d;
      valid_dreq_q <= valid_dreq_d;
      valid_dack_q <= valid_dack_d;
    end
  end

  // Polarity is applied combinationally so a command-register write
  // flips the pins in the same cycle.
  assign dack      = {NUM_CH{DACK_INACTIVE(dackActiveHigh)}} ^ grant_q;
  assign hrq       = hrq_q;
  assign validDREQ = valid_dreq_q;
  assign validDACK = valid_dack_q;
  assign activeCh  = active_ch_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] dreq, maskReg, reqReg, dack;
  logic       hlda, cmdDisable, cmdRotate, dreqActiveLow, dackActiveHigh;
  logic       serviceDone, hrq, validDREQ, validDACK;
  logic [1:0] activeCh;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .dreq(dreq), .hlda(hlda), .maskReg(maskReg),
    .reqReg(reqReg), .cmdDisable(cmdDisable), .cmdRotate(cmdRotate),
    .dreqActiveLow(dreqActiveLow), .dackActiveHigh(dackActiveHigh),
    .serviceDone(serviceDone), .hrq(hrq), .dack(dack), .validDREQ(validDREQ),
    .validDACK(validDACK), .activeCh(activeCh)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  bit act_low = 1'b0;
  bit dack_hi = 1'b0;
  int mptr    = 0;   // model priority pointer

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int model_winner(input logic [3:0] e, input int p);
    for (int k = 0; k < 4; k++)
      if (e[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] dack_exp(input int ch, input bit granted);
    logic [3:0] g;
    g = granted ? (4'b0001 << ch) : 4'b0000;
    return dack_hi ? g : ~g;
  endfunction

  function automatic logic [3:0] raw(input logic [3:0] d);
    return act_low ? ~d : d;
  endfunction

  task automatic quiet();
    hlda = 1'b0; serviceDone = 1'b0; reqReg = 4'h0; dreq = raw(4'h0);
    step(); step();
  endtask

  // Mask everything while polarity flips so the stale sampled DREQ can't qualify.
  task automatic set_pol(input bit al, input bit ah);
    maskReg = 4'hF; reqReg = 4'h0; act_low = al; dack_hi = ah;
    dreqActiveLow = al; dackActiveHigh = ah; dreq = raw(4'h0);
    #1;
    chk("dack_pol_idle", dack, dack_exp(0, 1'b0));
    step(); step();
  endtask

  // One full request/grant/release transaction.
  // end_mode: 0 serviceDone, 1 hlda loss, 2 both together.
  task automatic txn(input logic [3:0] d, input logic [3:0] m, input logic [3:0] r,
                     input bit dis, input bit rot, input int end_mode, input bit mid_dis);
    logic [3:0] e;
    int w, n;
    e = dis ? 4'h0 : ((d & ~m) | r);
    w = model_winner(e, mptr);
    dreq = raw(d); maskReg = m; reqReg = r; cmdDisable = dis; cmdRotate = rot;
    step();
    chk("hrq_early", hrq, (!dis && r != 4'h0));
    step();
    if (e == 4'h0) begin
      repeat (3) step();
      chk("hrq_none", hrq, 1'b0);
      chk("vdreq_none", validDREQ, 1'b0);
      cmdDisable = 1'b0;
      quiet();
      return;
    end
    chk("hrq_req", hrq, 1'b1);
    chk("vdreq", validDREQ, 1'b1);
    chk("active_ch", activeCh, w);
    chk("vdack_pre", validDACK, 1'b0);
    hlda = 1'b1;
    step();
    chk("vdack", validDACK, 1'b1);
    chk("dack_grant", dack, dack_exp(w, 1'b1));
    chk("hrq_hold", hrq, 1'b1);
    n = mid_dis ? 2 : $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if (mid_dis) cmdDisable = 1'b1;
      else if ($urandom_range(0, 1) == 1) begin dreq = raw(4'h0); reqReg = 4'h0; end
      step();
      chk("dack_held", dack, dack_exp(w, 1'b1));
      chk("ch_frozen", activeCh, w);
    end
    if (end_mode != 1) serviceDone = 1'b1;
    if (end_mode != 0) hlda = 1'b0;
    step();
    serviceDone = 1'b0;
    chk("hrq_rel", hrq, 1'b0);
    chk("vdack_rel", validDACK, 1'b0);
    chk("dack_rel", dack, dack_exp(0, 1'b0));
    if (ROT && rot && end_mode != 1) mptr = (w + 1) % 4;
    if (mid_dis) begin
      hlda = 1'b0;
      repeat (4) step();
      chk("dis_no_hrq", hrq, 1'b0);
    end
    quiet();
    cmdDisable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; dreq = 4'h0; hlda = 1'b0; maskReg = 4'h0; reqReg = 4'h0;
    cmdDisable = 1'b0; cmdRotate = 1'b0; dreqActiveLow = 1'b0;
    dackActiveHigh = 1'b0; serviceDone = 1'b0;
    step(); step();
    chk("rst_hrq", hrq, 1'b0);
    chk("rst_vdack", validDACK, 1'b0);
    chk("rst_vdreq", validDREQ, 1'b0);
    chk("rst_dack", dack, 4'b1111);
    chk("rst_ch", activeCh, 2'd0);
    RESET = 1'b0;

    set_pol(1'b0, 1'b1);
    txn(4'b0100, 4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    txn(4'b1010, 4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    txn(4'b1000, 4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) txn(4'b1111, 4'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    txn(4'b1111, 4'h0, 4'h0, 1'b0, 1'b1, 1, 1'b0);   // bus loss: no rotate
    txn(4'b1111, 4'h0, 4'h0, 1'b0, 1'b1, 2, 1'b0);
    txn(4'b0001, 4'b0001, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    txn(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
    txn(4'b0110, 4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b1);
    txn(4'b0110, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0);

    // Reset while a request is pending.
    dreq = raw(4'b0010); maskReg = 4'h0;
    step(); step();
    chk("pre_rst_hrq", hrq, 1'b1);
    RESET = 1'b1;
    step();
    chk("midrst_hrq", hrq, 1'b0);
    chk("midrst_ch", activeCh, 2'd0);
    chk("midrst_dack", dack, dack_exp(0, 1'b0));
    RESET = 1'b0;
    mptr = 0;
    quiet();

    for (int i = 0; i < 60; i++) begin
      logic [3:0] d, m, r;
      if (i % 8 == 0) set_pol($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      d = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      txn(d, m, r, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
